// File: rtl/systolic_drain_ctrl.sv
// systolic_drain_ctrl
// Unload sequencer for the systolic accumulator array. It steps row_sel
// through rows 0..N-1, registers each row word and offers it to the
// downstream consumer over valid/ready. When the last word is accepted it
// pulses done.
//
// Optional feature macro: DRAIN_SKEW_WAIT_EN
//   Defined   : a SKEW state waits N-1 cycles after start so that the last
//               diagonal wavefront can settle before row 0 is read.
//   Undefined : start goes straight to DRAIN. The upstream controller must
//               then issue start only after the array has settled.
module systolic_drain_ctrl #(
    parameter int N  = 64,
    parameter int CW = 7,
    parameter int DW = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [CW-1:0] row_sel,
    input  logic [DW-1:0] row_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);

`ifdef DRAIN_SKEW_WAIT_EN
    localparam logic [CW-1:0] SKEW_END = CW'(N - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKEW  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] row_sel_reg, row_sel_next;
    logic          out_valid_reg, out_valid_next;
    logic          out_last_reg, out_last_next;
    logic [DW-1:0] out_data_reg;
    logic          done_reg, done_next;
    logic          load_data;
    logic          ld;

`ifdef DRAIN_SKEW_WAIT_EN
    logic [CW-1:0] skew_cnt_reg, skew_cnt_next;
`endif

    // The output register may take a new word when empty or being emptied.
    assign ld = !out_valid_reg || out_ready;

    // Next-state and control decode; abort overrides every transition.
    always_comb begin
        state_next     = state_reg;
        row_sel_next   = row_sel_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        done_next      = 1'b0;
        load_data      = 1'b0;
`ifdef DRAIN_SKEW_WAIT_EN
        skew_cnt_next  = skew_cnt_reg;
`endif
        if (abort) begin
            state_next     = IDLE;
            row_sel_next   = '0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
`ifdef DRAIN_SKEW_WAIT_EN
            skew_cnt_next  = '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    row_sel_next   = '0;
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    if (start) begin
`ifdef DRAIN_SKEW_WAIT_EN
                        state_next = SKEW;
`else
                        state_next = DRAIN;
`endif
                    end
                end
`ifdef DRAIN_SKEW_WAIT_EN
                SKEW: begin
                    // N-1 cycles here: skew_cnt runs 0..N-2.
                    if (skew_cnt_reg == SKEW_END) begin
                        skew_cnt_next = '0;
                        state_next    = DRAIN;
                    end else begin
                        skew_cnt_next = skew_cnt_reg + CW'(1);
                    end
                end
`endif
                DRAIN: begin
                    if (ld) begin
                        load_data      = 1'b1;
                        out_valid_next = 1'b1;
                        out_last_next  = (row_sel_reg == LAST_ROW);
                        // row_sel parks at N-1; it only returns to 0 on FLUSH exit.
                        if (row_sel_reg == LAST_ROW) begin
                            state_next = FLUSH;
                        end else begin
                            row_sel_next = row_sel_reg + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (out_valid_reg && out_ready) begin
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        done_next      = 1'b1;
                        row_sel_next   = '0;
                        state_next     = IDLE;
                    end
                end
                default: begin
                    state_next     = IDLE;
                    row_sel_next   = '0;
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                end
            endcase
        end
    end

    // State and control register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            row_sel_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_sel_reg   <= row_sel_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            done_reg      <= done_next;
        end
    end

`ifdef DRAIN_SKEW_WAIT_EN
    // Settling-wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            skew_cnt_reg <= '0;
        end else begin
            skew_cnt_reg <= skew_cnt_next;
        end
    end
`endif

    // Row word register; only written on a load so it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg <= '0;
        end else if (load_data) begin
            out_data_reg <= row_data;
        end
    end

    assign row_sel   = row_sel_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_data  = out_data_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != IDLE);

endmodule
